// File: rtl/delay_pkg.sv
// Shared definitions for the delay queue: width helpers and the entry layout.
// Widths depend on module parameters, so helpers are functions the modules call.
package delay_pkg;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Enough bits to hold 0..latency, never narrower than one bit.
    function automatic int age_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_LATENCY = 1;
    localparam int AGE_W           = age_width(DEFAULT_LATENCY);

    // Entry layout for the default configuration; the top builds its own
    // parameterised equivalent from the same helpers.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic [AGE_W-1:0]         age;
    } entry_t;

endpackage

// File: rtl/delay_age_cnt.sv
// One saturating age counter: loads 1 when its slot is written, then counts up
// every cycle until it reaches LATENCY.
module delay_age_cnt
    import delay_pkg::*;
#(
    parameter int LATENCY = 1,
    localparam int AW = age_width(LATENCY)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    output logic [AW-1:0] age
);

    localparam logic [AW-1:0] SAT    = AW'(LATENCY);
    localparam logic [AW-1:0] LOAD_V = (LATENCY == 0) ? '0 : AW'(1);

    always_ff @(posedge clk) begin
        if (reset || clear)
            age <= '0;
        else if (load)
            age <= LOAD_V;
        else if (age < SAT)
            age <= age + AW'(1);
    end

endmodule

// File: rtl/delay_queue.sv
// FIFO whose entries become visible only after they have aged LATENCY cycles;
// with LATENCY = 0 an empty queue passes input straight through.
module delay_queue
    import delay_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = count_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int AW    = age_width(LATENCY);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    LAT_C   = AW'(LATENCY);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    age;
    } q_entry_t;

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [AW-1:0]    ages [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    q_entry_t         head;
    logic             empty, head_ok, fall_through;
    logic             push, pop, wr_en, rd_en;

    assign head  = '{data: mem[rd_ptr], age: ages[rd_ptr]};
    assign empty = (count == '0);

    generate
        if (LATENCY == 0) begin : g_lat0
            assign head_ok      = !empty;
            assign fall_through = empty && in_valid;
        end else begin : g_latn
            assign head_ok      = !empty && (head.age >= LAT_C);
            assign fall_through = 1'b0;
        end
    endgenerate

    always_comb begin
        in_ready  = (count < DEPTH_C) && !flush;
        out_valid = !flush && (head_ok || fall_through);
        out_data  = '0;
        if (out_valid)
            out_data = fall_through ? in_data : head.data;
    end

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    // A fall-through consumed in the same cycle never occupies a slot.
    assign wr_en = push && !(fall_through && out_ready);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the data array has no reset; stale contents are masked by count,
    // which keeps it a plain RAM without a clear path.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_data;
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_age
            delay_age_cnt #(.LATENCY(LATENCY)) u_age (
                .clk   (clk),
                .reset (reset),
                .clear (flush),
                .load  (wr_en && (wr_ptr == PTR_W'(i))),
                .age   (ages[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_delay_queue.sv
// Directed bench: three queue instances (LATENCY 3, 2 and 0) driven by a single
// linear sequence of cycles with hand-computed expectations.
module tb_delay_queue;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // a: LATENCY=3, b: LATENCY=2, c: LATENCY=0; all DEPTH=4, WIDTH=8
    logic       a_flush = 0, a_in_valid = 0, a_out_ready = 0, a_in_ready, a_out_valid;
    logic [7:0] a_in_data = 0, a_out_data;
    logic [2:0] a_count;
    logic       b_flush = 0, b_in_valid = 0, b_out_ready = 0, b_in_ready, b_out_valid;
    logic [7:0] b_in_data = 0, b_out_data;
    logic [2:0] b_count;
    logic       c_flush = 0, c_in_valid = 0, c_out_ready = 0, c_in_ready, c_out_valid;
    logic [7:0] c_in_data = 0, c_out_data;
    logic [2:0] c_count;

    delay_queue #(.WIDTH(8), .DEPTH(4), .LATENCY(3)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid),
        .in_data(a_in_data), .in_ready(a_in_ready), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_ready(a_out_ready), .count(a_count));

    delay_queue #(.WIDTH(8), .DEPTH(4), .LATENCY(2)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid),
        .in_data(b_in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_ready(b_out_ready), .count(b_count));

    delay_queue #(.WIDTH(8), .DEPTH(4), .LATENCY(0)) u_c (
        .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid),
        .in_data(c_in_data), .in_ready(c_in_ready), .out_valid(c_out_valid),
        .out_data(c_out_data), .out_ready(c_out_ready), .count(c_count));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) cyc();
        reset = 1'b0;
        smp();
        chk("rst_count", a_count, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_in_ready", a_in_ready, 1);

        // Single push of 0xA5 at LATENCY 3: visible three cycles later.
        cyc();
        a_out_ready = 1; a_in_valid = 1; a_in_data = 8'hA5;
        smp();
        chk("lat3_push_valid", a_out_valid, 0);
        cyc();
        a_in_valid = 0;
        smp();
        chk("lat3_n1_count", a_count, 1);
        chk("lat3_n1_valid", a_out_valid, 0);
        cyc(); smp();
        chk("lat3_n2_valid", a_out_valid, 0);
        cyc(); smp();
        chk("lat3_n3_valid", a_out_valid, 1);
        chk("lat3_n3_data", a_out_data, 8'hA5);
        cyc(); smp();
        chk("lat3_n4_count", a_count, 0);
        chk("lat3_n4_valid", a_out_valid, 0);
        chk("lat3_n4_data", a_out_data, 0);

        // Back-to-back stream 0x01..0x08, out_ready held high.
        for (int c = 0; c < 12; c++) begin
            cyc();
            a_in_valid = (c < 8);
            a_in_data  = 8'(c + 1);
            smp();
            chk("stream_in_ready", a_in_ready, 1);
            chk("stream_valid", a_out_valid, (c >= 3 && c <= 10) ? 1 : 0);
            chk("stream_data", a_out_data, (c >= 3 && c <= 10) ? c - 2 : 0);
        end
        a_in_valid = 0;

        // LATENCY 2 backpressure: fill to 4, hold 5th, then drain.
        for (int c = 0; c < 11; c++) begin
            cyc();
            b_in_valid  = (c < 7);
            b_in_data   = 8'((c < 4) ? c + 1 : 5);
            b_out_ready = (c >= 5);
            smp();
            case (c)
                0: chk("bp_c0_ready", b_in_ready, 1);
                1: chk("bp_c1_count", b_count, 1);
                2: begin
                    chk("bp_c2_valid", b_out_valid, 1);
                    chk("bp_c2_data", b_out_data, 1);
                end
                3: chk("bp_c3_ready", b_in_ready, 1);
                4: begin
                    chk("bp_full_ready", b_in_ready, 0);
                    chk("bp_full_count", b_count, 4);
                    chk("bp_hold_data", b_out_data, 1);
                end
                5: begin
                    chk("bp_c5_ready", b_in_ready, 0);
                    chk("bp_c5_data", b_out_data, 1);
                end
                6: begin
                    chk("bp_c6_ready", b_in_ready, 1);
                    chk("bp_c6_count", b_count, 3);
                    chk("bp_c6_data", b_out_data, 2);
                end
                7: begin
                    chk("bp_c7_count", b_count, 3);
                    chk("bp_c7_data", b_out_data, 3);
                end
                8: chk("bp_c8_data", b_out_data, 4);
                9: begin
                    chk("bp_c9_valid", b_out_valid, 1);
                    chk("bp_c9_data", b_out_data, 5);
                    chk("bp_c9_count", b_count, 1);
                end
                10: begin
                    chk("bp_c10_count", b_count, 0);
                    chk("bp_c10_valid", b_out_valid, 0);
                end
                default: ;
            endcase
        end

        // LATENCY 2 flush with a concurrent push.
        b_out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            b_in_valid = 1; b_in_data = 8'(8'h11 * (c + 1));
            smp();
        end
        chk("fl_pre_valid", b_out_valid, 1);
        chk("fl_pre_data", b_out_data, 8'h11);
        cyc();
        b_flush = 1; b_in_valid = 1; b_in_data = 8'hEE;
        smp();
        chk("fl_cyc_count", b_count, 3);
        chk("fl_cyc_valid", b_out_valid, 0);
        chk("fl_cyc_ready", b_in_ready, 0);
        cyc();
        b_flush = 0; b_in_valid = 0; b_out_ready = 1;
        smp();
        chk("fl_post_count", b_count, 0);
        chk("fl_post_valid", b_out_valid, 0);
        chk("fl_post_data", b_out_data, 0);
        for (int c = 0; c < 3; c++) begin
            cyc(); smp();
            chk("fl_never_valid", b_out_valid, 0);
        end

        // LATENCY 0 fall-through, then a non-popped fall-through that enqueues.
        cyc();
        c_in_valid = 1; c_in_data = 8'h3C; c_out_ready = 1;
        smp();
        chk("ft_valid", c_out_valid, 1);
        chk("ft_data", c_out_data, 8'h3C);
        chk("ft_count", c_count, 0);
        cyc();
        c_in_valid = 0;
        smp();
        chk("ft_after_count", c_count, 0);
        chk("ft_after_valid", c_out_valid, 0);
        cyc();
        c_in_valid = 1; c_in_data = 8'h5A; c_out_ready = 0;
        smp();
        chk("ft_stall_valid", c_out_valid, 1);
        chk("ft_stall_data", c_out_data, 8'h5A);
        cyc();
        c_in_valid = 0;
        smp();
        chk("ft_enq_count", c_count, 1);
        chk("ft_enq_data", c_out_data, 8'h5A);
        cyc();
        c_out_ready = 1;
        smp();
        chk("ft_pop_valid", c_out_valid, 1);
        cyc(); smp();
        chk("ft_pop_count", c_count, 0);

        // Reset mid-operation on LATENCY 3 with two entries, head visible.
        a_out_ready = 0;
        cyc();
        a_in_valid = 1; a_in_data = 8'h11;
        smp();
        cyc();
        a_in_data = 8'h22;
        smp();
        cyc();
        a_in_valid = 0;
        smp();
        cyc(); smp();
        chk("mr_pre_count", a_count, 2);
        chk("mr_pre_valid", a_out_valid, 1);
        chk("mr_pre_data", a_out_data, 8'h11);
        cyc();
        reset = 1;
        smp();
        cyc();
        reset = 0;
        smp();
        chk("mr_count", a_count, 0);
        chk("mr_valid", a_out_valid, 0);
        chk("mr_data", a_out_data, 0);
        chk("mr_ready", a_in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
